sequence_generator: RTL and testbench
=====================================

Name: sequence_generator

Overview:
Serial pattern transmitter: the sending end of the bit-serial sequence-detection path. On a start request it latches a PAT_W-bit pattern and shifts it out MSB-first on DATA_OUT, one bit per clk, repeated a programmable number of times with an optional idle gap between repetitions. It drives the sequence detector in loopback benches and feeds serial pattern traffic to downstream logic.

Parameters:
PAT_W, 6, pattern length in bits (>= 2)
DEFAULT_PAT, 6'b110100, pattern used when use_default = 1
CNT_W, 8, width of repetition counter
GAP_W, 4, width of inter-repetition gap length

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  request; sampled only in IDLE
use_default  input  1  1 = send DEFAULT_PAT, 0 = send pattern; sampled with start
pattern  input  PAT_W  pattern to send, MSB first; sampled with start
rep_cnt  input  CNT_W  number of repetitions; 0 treated as 1; sampled with start
gap_len  input  GAP_W  idle cycles between repetitions; sampled with start
DATA_OUT  output  1  serial data, registered
valid  output  1  DATA_OUT carries a pattern bit this cycle
frame_start  output  1  pulse on the first bit of each repetition
busy  output  1  high from accepted start until the last bit ends
done  output  1  one-cycle pulse after the final bit

Behaviour:
- Reset (rst = 0, asynchronous): state = IDLE; DATA_OUT, valid, frame_start, busy, done = 0; internal pattern, bit, repetition and gap counters cleared. Applies immediately mid-operation; the frame is abandoned, nothing resumes after rst releases.
- All outputs are registered. DATA_OUT = 0 whenever valid = 0.
- FSM states: IDLE, SEND, GAP, FIN.
- IDLE: busy = 0. If start = 1 at edge k: latch pattern (or DEFAULT_PAT), rep_cnt (0 -> 1), gap_len; go to SEND. From edge k: DATA_OUT = MSB, valid = 1, frame_start = 1, busy = 1. First bit is visible one cycle after start is sampled.
- SEND: shift out one bit per edge, MSB to LSB, for PAT_W cycles. frame_start = 1 only on bit 0 of each repetition.
- After the LSB of a repetition:
  - If repetitions remain and gap_len = 0: the next repetition's MSB follows on the very next edge. There are no idle cycles and valid stays high.
  - If repetitions remain and gap_len > 0: go to GAP for exactly gap_len cycles with valid = 0, DATA_OUT = 0, busy = 1. Then go to SEND.
  - If this was the last repetition: go to FIN.
- FIN: lasts one cycle. done = 1, busy = 0, valid = 0. Then go to IDLE. A start in FIN is ignored; a start in the following IDLE cycle is accepted.
- start while busy (SEND/GAP) is ignored. Changes to pattern, rep_cnt, gap_len or use_default after acceptance have no effect on the frame in progress.
- Total busy cycles = rep*PAT_W + (rep-1)*gap_len.
- Counter wrap: the repetition counter counts down from the latched value and never wraps. Max rep = 2^CNT_W - 1; rep_cnt = 0 is treated as 1.

Test Plan:
- Default single: use_default = 1, rep_cnt = 1, gap_len = 0, start pulse. Required response:
  - DATA_OUT = 1,1,0,1,0,0 over the 6 cycles after start; valid = 1 and busy = 1 for those 6 cycles; frame_start on the first bit only.
  - done = 1 on the 7th cycle; busy = 0 at that point.
- Back-to-back repeats: pattern = 6'b101101, rep_cnt = 3, gap_len = 0. Required response: 18 contiguous valid bits, 101101 repeated three times; frame_start at cycles 1, 7 and 13; done at cycle 19.
- Gap: default pattern, rep_cnt = 2, gap_len = 2. Required response: 6 bits, then 2 cycles of valid = 0 and DATA_OUT = 0, then 6 bits; busy high for 14 cycles; done at cycle 15.
- Ignored start and rep_cnt = 0:
  - Pulse start again mid-frame: output is unchanged and exactly one done pulse occurs.
  - rep_cnt = 0: exactly one repetition is sent.
- Reset mid-frame: drive rst = 0 during bit 3. Required response: all outputs 0 in the same cycle; after release, outputs stay idle until a new start.
- Loopback: DATA_OUT drives the sequence detector's DATA_IN; default pattern, rep_cnt = 4, gap_len = 0. Required response: the detector raises its found flag exactly 4 times, one cycle after each final 0 bit.

Source files
------------

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: latches a PAT_W-bit pattern on start and shifts it
// out MSB-first, repeated rep_cnt times with an optional idle gap between repetitions.
module sequence_generator #(
    parameter int               PAT_W       = 6,
    parameter logic [PAT_W-1:0] DEFAULT_PAT = 6'b110100,
    parameter int               CNT_W       = 8,
    parameter int               GAP_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             use_default,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] rep_cnt,
    input  logic [GAP_W-1:0] gap_len,
    output logic             DATA_OUT,
    output logic             valid,
    output logic             frame_start,
    output logic             busy,
    output logic             done
);

    localparam int BW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(PAT_W - 1);

    typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} state_t;

    state_t           state;
    logic [PAT_W-1:0] pat_q;
    logic [PAT_W-1:0] sr;
    logic [BW-1:0]    bit_idx;
    logic [CNT_W-1:0] rep_left;
    logic [GAP_W-1:0] gap_q;
    logic [GAP_W-1:0] gap_cnt;
    logic [PAT_W-1:0] sel_pat;

    always_comb begin
        sel_pat = use_default ? DEFAULT_PAT : pattern;
    end

    // bit_idx tracks the bit currently on DATA_OUT; sr holds the bits still to come.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            pat_q       <= '0;
            sr          <= '0;
            bit_idx     <= '0;
            rep_left    <= '0;
            gap_q       <= '0;
            gap_cnt     <= '0;
            DATA_OUT    <= 1'b0;
            valid       <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        pat_q       <= sel_pat;
                        sr          <= sel_pat << 1;
                        rep_left    <= (rep_cnt == '0) ? CNT_W'(1) : rep_cnt;
                        gap_q       <= gap_len;
                        bit_idx     <= '0;
                        DATA_OUT    <= sel_pat[PAT_W-1];
                        valid       <= 1'b1;
                        frame_start <= 1'b1;
                        busy        <= 1'b1;
                        state       <= SEND;
                    end
                end
                SEND: begin
                    if (bit_idx != LAST_BIT) begin
                        bit_idx     <= bit_idx + 1'b1;
                        DATA_OUT    <= sr[PAT_W-1];
                        sr          <= sr << 1;
                        frame_start <= 1'b0;
                    end else if (rep_left > CNT_W'(1)) begin
                        rep_left <= rep_left - 1'b1;
                        bit_idx  <= '0;
                        if (gap_q == '0) begin
                            DATA_OUT    <= pat_q[PAT_W-1];
                            sr          <= pat_q << 1;
                            frame_start <= 1'b1;
                        end else begin
                            gap_cnt     <= gap_q;
                            DATA_OUT    <= 1'b0;
                            valid       <= 1'b0;
                            frame_start <= 1'b0;
                            state       <= GAP;
                        end
                    end else begin
                        DATA_OUT    <= 1'b0;
                        valid       <= 1'b0;
                        frame_start <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= FIN;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_W'(1)) begin
                        DATA_OUT    <= pat_q[PAT_W-1];
                        sr          <= pat_q << 1;
                        valid       <= 1'b1;
                        frame_start <= 1'b1;
                        state       <= SEND;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sequence_generator.sv
// Directed bench for sequence_generator with a small serial detector for loopback.
module tb_sequence_generator;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       use_default = 1'b0;
    logic [5:0] pattern = '0;
    logic [7:0] rep_cnt = '0;
    logic [3:0] gap_len = '0;
    logic       DATA_OUT, valid, frame_start, busy, done;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sequence_generator dut (
        .clk(clk), .rst(rst), .start(start), .use_default(use_default),
        .pattern(pattern), .rep_cnt(rep_cnt), .gap_len(gap_len),
        .DATA_OUT(DATA_OUT), .valid(valid), .frame_start(frame_start),
        .busy(busy), .done(done)
    );

    // Loopback detector: found rises the cycle after 110100 has been received.
    logic [5:0] win;
    logic       found;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win   <= '0;
            found <= 1'b0;
        end else begin
            win   <= {win[4:0], DATA_OUT};
            found <= ({win[4:0], DATA_OUT} == 6'b110100);
        end
    end

    // Leaves the bench #1 after the edge that accepted start (cycle 1).
    task automatic kick(input logic ud, input logic [5:0] p, input logic [7:0] r, input logic [3:0] g);
        @(negedge clk);
        use_default = ud; pattern = p; rep_cnt = r; gap_len = g; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        checks++;
        if ({DATA_OUT, valid, frame_start, busy, done} !== 5'b0) begin
            failures++;
            $display("FAIL reset_state: got %b want 00000", {DATA_OUT, valid, frame_start, busy, done});
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) next_cycle();
        checks++;
        if ({DATA_OUT, valid, frame_start, busy, done} !== 5'b0) begin
            failures++;
            $display("FAIL reset_idle: got %b want 00000", {DATA_OUT, valid, frame_start, busy, done});
        end
    endtask

    task automatic test_default_single();
        logic [5:0] exp_d;
        exp_d = 6'b110100;
        kick(1'b1, 6'b000000, 8'd1, 4'd0);
        for (int c = 1; c <= 6; c++) begin
            checks++;
            if ({DATA_OUT, valid, busy, frame_start} !== {exp_d[6-c], 1'b1, 1'b1, (c == 1)}) begin
                failures++;
                $display("FAIL single_bit%0d: got d/v/b/fs=%b want %b", c,
                         {DATA_OUT, valid, busy, frame_start}, {exp_d[6-c], 1'b1, 1'b1, (c == 1)});
            end
            next_cycle();
        end
        checks++;
        if ({done, busy, valid, DATA_OUT} !== 4'b1000) begin
            failures++;
            $display("FAIL single_done: got done/busy/valid/d=%b want 1000", {done, busy, valid, DATA_OUT});
        end
        next_cycle();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL single_done_pulse: got done=%b want 0", done);
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] exp_d;
        exp_d = 18'b101101_101101_101101;
        kick(1'b0, 6'b101101, 8'd3, 4'd0);
        for (int c = 1; c <= 18; c++) begin
            checks++;
            if ({DATA_OUT, valid, busy, frame_start} !== {exp_d[18-c], 1'b1, 1'b1, (c == 1 || c == 7 || c == 13)}) begin
                failures++;
                $display("FAIL b2b_bit%0d: got d/v/b/fs=%b want %b", c, {DATA_OUT, valid, busy, frame_start},
                         {exp_d[18-c], 1'b1, 1'b1, (c == 1 || c == 7 || c == 13)});
            end
            next_cycle();
        end
        checks++;
        if ({done, busy, valid} !== 3'b100) begin
            failures++;
            $display("FAIL b2b_done: got done/busy/valid=%b want 100", {done, busy, valid});
        end
        next_cycle();
    endtask

    task automatic test_gap();
        logic [13:0] exp_d, exp_v;
        exp_d = 14'b110100_00_110100;
        exp_v = 14'b111111_00_111111;
        kick(1'b1, 6'b000000, 8'd2, 4'd2);
        for (int c = 1; c <= 14; c++) begin
            checks++;
            if ({DATA_OUT, valid, busy, frame_start} !== {exp_d[14-c], exp_v[14-c], 1'b1, (c == 1 || c == 9)}) begin
                failures++;
                $display("FAIL gap_cyc%0d: got d/v/b/fs=%b want %b", c, {DATA_OUT, valid, busy, frame_start},
                         {exp_d[14-c], exp_v[14-c], 1'b1, (c == 1 || c == 9)});
            end
            next_cycle();
        end
        checks++;
        if ({done, busy, valid} !== 3'b100) begin
            failures++;
            $display("FAIL gap_done: got done/busy/valid=%b want 100", {done, busy, valid});
        end
        next_cycle();
    endtask

    task automatic test_ignored_start();
        logic [5:0] exp_d;
        int dones;
        exp_d = 6'b110100;
        dones = 0;
        kick(1'b1, 6'b000000, 8'd1, 4'd0);
        for (int c = 1; c <= 10; c++) begin
            if (c <= 6) begin
                checks++;
                if ({DATA_OUT, valid} !== {exp_d[6-c], 1'b1}) begin
                    failures++;
                    $display("FAIL ignore_bit%0d: got d/v=%b want %b", c, {DATA_OUT, valid}, {exp_d[6-c], 1'b1});
                end
            end
            if (done === 1'b1) dones++;
            // Mid-frame start with new inputs, then a start held during FIN.
            start = (c == 3 || c == 7);
            use_default = (c == 3) ? 1'b0 : 1'b1;
            pattern = 6'b011011;
            rep_cnt = 8'd5;
            next_cycle();
            start = 1'b0;
        end
        checks++;
        if (dones !== 1) begin
            failures++;
            $display("FAIL ignore_done_count: got %0d want 1", dones);
        end
        checks++;
        if ({valid, busy} !== 2'b00) begin
            failures++;
            $display("FAIL ignore_fin_start: got valid/busy=%b want 00", {valid, busy});
        end
    endtask

    task automatic test_rep_zero();
        int nvalid;
        nvalid = 0;
        kick(1'b1, 6'b000000, 8'd0, 4'd3);
        for (int c = 1; c <= 6; c++) begin
            if (valid === 1'b1) nvalid++;
            next_cycle();
        end
        checks++;
        if ({nvalid, done} !== {32'd6, 1'b1}) begin
            failures++;
            $display("FAIL rep_zero: got bits=%0d done=%b want bits=6 done=1", nvalid, done);
        end
        next_cycle();
        checks++;
        if ({valid, busy, done} !== 3'b000) begin
            failures++;
            $display("FAIL rep_zero_after: got valid/busy/done=%b want 000", {valid, busy, done});
        end
    endtask

    task automatic test_reset_mid();
        kick(1'b1, 6'b000000, 8'd2, 4'd0);
        next_cycle();
        next_cycle();
        rst = 1'b0;
        #1;
        checks++;
        if ({DATA_OUT, valid, frame_start, busy, done} !== 5'b0) begin
            failures++;
            $display("FAIL reset_mid: got %b want 00000", {DATA_OUT, valid, frame_start, busy, done});
        end
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 8; c++) begin
            next_cycle();
            checks++;
            if ({DATA_OUT, valid, frame_start, busy, done} !== 5'b0) begin
                failures++;
                $display("FAIL reset_release%0d: got %b want 00000", c, {DATA_OUT, valid, frame_start, busy, done});
            end
        end
    endtask

    task automatic test_loopback();
        int hits;
        hits = 0;
        kick(1'b1, 6'b000000, 8'd4, 4'd0);
        for (int c = 1; c <= 30; c++) begin
            if (found === 1'b1) begin
                hits++;
                checks++;
                if (c != 7 && c != 13 && c != 19 && c != 25) begin
                    failures++;
                    $display("FAIL loop_found_time: got found at cycle %0d want 7/13/19/25", c);
                end
            end
            next_cycle();
        end
        checks++;
        if (hits !== 4) begin
            failures++;
            $display("FAIL loop_found_count: got %0d want 4", hits);
        end
    endtask

    initial begin
        test_reset();
        test_default_single();
        test_back_to_back();
        test_gap();
        test_ignored_start();
        test_rep_zero();
        test_reset_mid();
        test_loopback();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
